// File: rtl/radar_display_ctrl.sv
// Radar display pixel pipeline: origin-relative coordinates, 8-entry target buffer, marker compositing.
// Define RADAR_FADE_EN to compile in per-target aging and dimming.
module radar_display_ctrl #(
  parameter int          ORIGIN_X     = 512,
  parameter int          ORIGIN_Y     = 704,
  parameter int          V_ACTIVE     = 768,
  parameter int          TGT_RADIUS   = 4,
  parameter logic [23:0] TARGET_COLOR = 24'h00_FF_00,
  parameter int          FADE_FRAMES  = 60
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank,
  output logic signed [11:0] grid_x,
  output logic signed [11:0] grid_y,
  input  logic [23:0]        grid_pixel,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic signed [11:0] tgt_x,
  input  logic signed [11:0] tgt_y,
  input  logic               tgt_clear,
  output logic [23:0]        pixel_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               blank_out,
  output logic               busy
);

`ifdef RADAR_FADE_EN
  typedef enum logic [1:0] {IDLE, CLEAR, AGE} state_t;
  localparam logic [5:0]  AGE_INIT  = 6'(FADE_FRAMES);
  localparam logic [5:0]  AGE_HALF  = 6'(FADE_FRAMES / 2);
  localparam logic [23:0] DIM_COLOR = {1'b0, TARGET_COLOR[23:17], 1'b0, TARGET_COLOR[15:9],
                                       1'b0, TARGET_COLOR[7:1]};
  logic [5:0] ent_age [8];
  logic       clr_pend;
`else
  typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif
  localparam logic [12:0] RAD = 13'(TGT_RADIUS);

  state_t            state, state_n;
  logic [2:0]        idx, ptr;
  logic [7:0]        ent_v;
  logic signed [11:0] ent_x [8];
  logic signed [11:0] ent_y [8];
  logic              hs1, vs1, bl1, vs_q, frame_tick, wr_en;
  logic              hit, dim;
  logic signed [12:0] dx, dy;
  logic [12:0]       adx, ady;

  // Stage 1: coordinates and timing
  always_ff @(posedge clock) begin
    if (reset) begin
      grid_x <= '0;
      grid_y <= '0;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      bl1    <= 1'b1;
      vs_q   <= 1'b1;
    end else begin
      grid_x <= {1'b0, hcount} - 12'(ORIGIN_X);
      grid_y <= 12'(ORIGIN_Y) - {2'b00, vcount};
      hs1    <= hsync;
      vs1    <= vsync;
      bl1    <= blank;
      vs_q   <= vsync;
    end
  end

  assign frame_tick = vs_q & ~vsync;
  assign tgt_ready  = (state == IDLE) & (vcount >= 10'(V_ACTIVE)) & ~tgt_clear & ~frame_tick & ~reset;
  assign wr_en      = tgt_valid & tgt_ready;
  assign busy       = (state != IDLE);

  // Scan high-to-low so the lowest matching index decides the colour
  always_comb begin
    hit = 1'b0;
    dim = 1'b0;
    dx  = '0;
    dy  = '0;
    adx = '0;
    ady = '0;
    for (int i = 7; i >= 0; i--) begin
      dx  = {grid_x[11], grid_x} - {ent_x[i][11], ent_x[i]};
      dy  = {grid_y[11], grid_y} - {ent_y[i][11], ent_y[i]};
      adx = dx[12] ? -dx : dx;
      ady = dy[12] ? -dy : dy;
      if (ent_v[i] && adx <= RAD && ady <= RAD) begin
        hit = 1'b1;
`ifdef RADAR_FADE_EN
        dim = (ent_age[i] < AGE_HALF);
`else
        dim = 1'b0;
`endif
      end
    end
  end

  // Stage 2: composite
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_out <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      hsync_out <= hs1;
      vsync_out <= vs1;
      blank_out <= bl1;
      if (bl1)
        pixel_out <= '0;
      else if (hit)
`ifdef RADAR_FADE_EN
        pixel_out <= dim ? DIM_COLOR : TARGET_COLOR;
`else
        pixel_out <= dim ? 24'h0 : TARGET_COLOR;
`endif
      else
        pixel_out <= grid_pixel;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (tgt_clear) state_n = CLEAR;
`ifdef RADAR_FADE_EN
        else if (frame_tick) state_n = AGE;
`endif
      end
      CLEAR: if (idx == 3'd7) state_n = IDLE;
`ifdef RADAR_FADE_EN
      AGE: if (idx == 3'd7) state_n = (clr_pend | tgt_clear) ? CLEAR : IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) idx <= '0;
      else if (state != IDLE) idx <= idx + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_v <= '0;
      ptr   <= '0;
`ifdef RADAR_FADE_EN
      clr_pend <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        ent_v[ptr] <= 1'b1;
        ptr        <= ptr + 3'd1;
      end
      if (state == CLEAR) begin
        ent_v[idx] <= 1'b0;
        if (idx == 3'd7) ptr <= '0;
      end
`ifdef RADAR_FADE_EN
      if (state == AGE) begin
        if (ent_v[idx] && ent_age[idx] == 6'd1) ent_v[idx] <= 1'b0;
        if (idx == 3'd7) clr_pend <= 1'b0;
        else if (tgt_clear) clr_pend <= 1'b1;
      end
`endif
    end
  end

  // Payload needs no reset; only the valid bits gate it
  always_ff @(posedge clock) begin
    if (wr_en) begin
      ent_x[ptr] <= tgt_x;
      ent_y[ptr] <= tgt_y;
`ifdef RADAR_FADE_EN
      ent_age[ptr] <= AGE_INIT;
`endif
    end
`ifdef RADAR_FADE_EN
    if (!reset && state == AGE && ent_v[idx] && ent_age[idx] != 6'd0)
      ent_age[idx] <= ent_age[idx] - 6'd1;
`endif
  end

endmodule

// File: doc/radar_display_ctrl.md
# radar_display_ctrl

Pixel-pipeline controller for the polar radar display. It converts XVGA `hcount`/`vcount` into the signed origin-relative `x`/`y` coordinates consumed by the background grid generator, and keeps an 8-entry buffer of detected target positions written by the ultrasound processing logic. It composites target markers over the grid pixel and re-times `hsync`/`vsync`/`blank` to match the pipeline. It sits between the XVGA timing generator and the VGA output registers.

## Interface
Parameters:
- `ORIGIN_X`, default 512: screen column where x = 0.
- `ORIGIN_Y`, default 704: screen row where y = 0; y increases upward.
- `V_ACTIVE`, default 768: first vertical-blanking row; the update window is vcount ≥ V_ACTIVE.
- `TGT_RADIUS`, default 4: half-width of the square target marker, in pixels.
- `TARGET_COLOR`, default 24'h00_FF_00: marker colour.
- `FADE_FRAMES`, default 60: initial target age. Used only with `RADAR_FADE_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clock` input 1: pixel clock.
- `reset` input 1: synchronous, active-high.
- `hcount` input 11, `vcount` input 10: XVGA pixel position.
- `hsync`, `vsync`, `blank` inputs 1: XVGA timing; syncs are active-low.
- `grid_x`, `grid_y` outputs 12, signed: coordinates sent to the grid generator.
- `grid_pixel` input 24: grid colour, combinational from `grid_x`/`grid_y`.
- `tgt_valid` input 1, `tgt_ready` output 1: target write handshake.
- `tgt_x`, `tgt_y` inputs 12, signed: target position.
- `tgt_clear` input 1: single-cycle pulse that invalidates all targets.
- `pixel_out` output 24; `hsync_out`, `vsync_out`, `blank_out` outputs 1: re-timed video.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
**Stage 1 (registered coordinates)**
- grid_x = hcount − ORIGIN_X.
- grid_y = ORIGIN_Y − vcount.
- Both are computed in 12-bit signed, with the inputs zero-extended first.
- hcount/vcount/syncs/blank are registered alongside.

**Stage 2 (registered composite)**
- A target hit occurs when any valid entry satisfies |grid_x − tx| ≤ TGT_RADIUS and |grid_y − ty| ≤ TGT_RADIUS. Differences are computed at 13 bits so they cannot overflow.
- Colour priority: blank → 0; target hit → target colour; otherwise grid_pixel.
- When several entries hit, the colour comes from the lowest index.

**Target buffer**
- 8 entries, each holding {valid, tx, ty, age[5:0]}, plus a 3-bit write pointer.
- A write is accepted on tgt_valid & tgt_ready. It stores the target into entry[ptr] with valid = 1 and age = FADE_FRAMES, then ptr increments, wrapping 7 → 0.
- When all entries are valid, the write overwrites the oldest-written entry.
- tgt_ready = (state == IDLE) & (vcount ≥ V_ACTIVE) & !tgt_clear & !frame_tick.

**frame_tick**
- One-cycle pulse on a registered falling edge of vsync.

**FSM states**
- IDLE
  - tgt_clear → CLEAR, with the index counter set to 0.
  - frame_tick (with `RADAR_FADE_EN` compiled in) → AGE, with the index counter set to 0.
  - If both occur in the same cycle, tgt_clear wins.
- CLEAR: zero entry[idx].valid each cycle. After idx = 7: set ptr = 0 and return to IDLE (8 cycles total).
- AGE: once per cycle, for a valid entry with age > 0, decrement age; an entry whose age becomes 0 gets valid = 0. After idx = 7, return to IDLE.
- A tgt_clear arriving during AGE is latched and serviced (goes to CLEAR) immediately after AGE. A frame_tick during CLEAR is dropped, so no aging occurs that frame.

**Mid-operation reset**
- Reset during CLEAR or AGE forces the full reset state in the next cycle.

## Timing
- Latency: pixel_out/hsync_out/vsync_out/blank_out correspond to the hcount/vcount sampled 2 clocks earlier. grid_x/grid_y lag hcount/vcount by 1 clock.
- grid_pixel is sampled at the end of stage 2's cycle. The grid generator must settle in less than 1 clock.
- Buffer updates take effect on the clock edge after acceptance. Because writes happen only during vblank, the visible frame never tears.

**Reset values**
- pixel_out = 0; hsync_out = vsync_out = blank_out = 1.
- grid_x = grid_y = 0.
- tgt_ready = 0, busy = 0.
- All entries invalid; ptr = 0; FSM in IDLE; latched clear = 0.

## Configuration
`RADAR_FADE_EN` compiles the target persistence feature in or out.

**Defined:**
- AGE state and per-entry age counters are present.
- An entry whose age is below FADE_FRAMES/2 renders TARGET_COLOR with each 8-bit channel shifted right by 1.
- An entry expires after FADE_FRAMES frame ticks.

**Undefined:**
- No AGE state; frame_tick only affects tgt_ready.
- Entries persist until overwritten or cleared.
- Markers always render at full TARGET_COLOR.

## Test plan
- hcount = 512, vcount = 704, after 1 clock → grid_x = 0, grid_y = 0. With hcount = 0, vcount = 0 → grid_x = −512, grid_y = 704. pixel_out follows grid_pixel 2 clocks later.
- Write (tx = 20, ty = 100) during vcount = 770 → tgt_ready high, accepted. Next frame, pixel at grid (24, 96) = 24'h00FF00; pixel at (25, 100) = grid_pixel.
- Pulse tgt_valid while vcount = 100 → tgt_ready stays 0 and no entry changes. Then write 9 targets → the 9th lands in entry 0 and ptr = 1.
- tgt_clear asserted in the same cycle as tgt_valid → write dropped, busy high for exactly 8 cycles, all markers gone afterward.
- With `RADAR_FADE_EN` and FADE_FRAMES = 60: after 31 frame ticks, the marker renders 24'h007F00; after 60 ticks, the entry is invalid. Reset asserted mid-AGE → all outputs at reset values the next cycle.
- blank = 1 over a target pixel → pixel_out = 0; blank_out/vsync_out delayed exactly 2 clocks.
